data_ram_bm: RTL

- Byte-addressed, big-endian data memory for the CPU load/store path; successor to the single-width word RAM.
- Supports byte, halfword and word accesses, with sign/zero extension on loads.
- Supports misaligned accesses; an access that crosses a row boundary is split into two cycles.
- Storage is organised as rows of WORD_BYTES bytes with per-byte write enables, one row address per cycle, so it infers into iCE40 BRAM. It uses a req/ready handshake towards the memory stage.

---
 rtl/data_ram_bm.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/data_ram_bm.sv
// Big-endian byte/half/word data RAM with per-byte row writes; misaligned accesses crossing a row take an extra cycle.
// Latency: ready in the 2nd cycle (3rd when crossing) after req is sampled; req is ignored while busy is high.
module data_ram_bm #(
    parameter int    ADDR_WIDTH = 12,
    parameter int    WORD_BYTES = 4,
    parameter int    BYTE_W     = 8,
    parameter string INIT_FILE  = ""
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req,
    input  logic                           we,
    input  logic [1:0]                     size,
    input  logic                           sext,
    input  logic [WORD_BYTES*BYTE_W-1:0]   ad,
    input  logic [WORD_BYTES*BYTE_W-1:0]   d,
    output logic [WORD_BYTES*BYTE_W-1:0]   q,
    output logic                           ready,
    output logic                           busy,
    output logic                           err
);
    localparam int FULLW = WORD_BYTES * BYTE_W;
    localparam int LG    = $clog2(WORD_BYTES);
    localparam int RW    = ADDR_WIDTH - LG;

    typedef enum logic [1:0] {IDLE, SPLIT, RESP} state_t;
    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] ad_q;
    logic [FULLW-1:0]      d_q, part, q_hold, rdata, row_part, resp_val;
    logic [1:0]            size_q;
    logic                  we_q, sext_q, err_q;
    logic [RW-1:0]         row_q;

    function automatic logic [LG:0] len_of(input logic [1:0] s);
        case (s)
            2'b00:   return (LG+1)'(1);
            2'b01:   return (LG+1)'(2);
            default: return (LG+1)'(WORD_BYTES);
        endcase
    endfunction

    logic [LG:0]  len_in, len_q;
    logic [FULLW:0] last_in;
    logic         err_in, cross_in, accept;

    assign len_in   = len_of(size);
    assign len_q    = len_of(size_q);
    assign last_in  = {1'b0, ad} + (FULLW+1)'(len_in) - (FULLW+1)'(1);
    assign err_in   = (size == 2'b11) || (|last_in[FULLW:ADDR_WIDTH]);
    assign cross_in = ({1'b0, ad[LG-1:0]} + len_in) > (LG+1)'(WORD_BYTES);
    assign accept   = (state == IDLE) && req;

    // Row access of this cycle: the new request in IDLE, the second row in SPLIT
    logic [ADDR_WIDTH-1:0] acc_ad;
    logic [LG:0]           acc_len;
    logic [FULLW-1:0]      acc_d, wr_dat;
    logic                  acc_we, acc_on;
    logic [RW-1:0]         acc_row;
    logic [WORD_BYTES-1:0] wr_en;

    assign acc_ad  = (state == IDLE) ? ad[ADDR_WIDTH-1:0] : ad_q;
    assign acc_len = (state == IDLE) ? len_in : len_q;
    assign acc_d   = (state == IDLE) ? d : d_q;
    assign acc_we  = (state == IDLE) ? we : we_q;
    assign acc_row = (state == IDLE) ? ad[ADDR_WIDTH-1:LG] : row_q + RW'(1);
    assign acc_on  = rst_n && ((accept && !err_in) || (state == SPLIT));

    always_comb begin
        logic [ADDR_WIDTH:0] off;
        logic [LG:0]         s;
        wr_en  = '0;
        wr_dat = '0;
        for (int l = 0; l < WORD_BYTES; l++) begin
            off = {1'b0, acc_row, LG'(l)} - {1'b0, acc_ad};
            s   = acc_len - (LG+1)'(1) - off[LG:0];
            if (off < (ADDR_WIDTH+1)'(acc_len)) begin
                wr_en[l]                 = acc_on && acc_we;
                wr_dat[l*BYTE_W +: BYTE_W] = acc_d[s*BYTE_W +: BYTE_W];
            end
        end
    end

    logic [FULLW-1:0] mem [2**RW];

    // Write-first read port so a store reads back its own new bytes
    always_ff @(posedge clk) begin
        for (int l = 0; l < WORD_BYTES; l++) begin
            if (wr_en[l])
                mem[acc_row][l*BYTE_W +: BYTE_W] <= wr_dat[l*BYTE_W +: BYTE_W];
            rdata[l*BYTE_W +: BYTE_W] <= wr_en[l] ? wr_dat[l*BYTE_W +: BYTE_W]
                                                  : mem[acc_row][l*BYTE_W +: BYTE_W];
        end
    end

    always_comb begin
        logic [ADDR_WIDTH:0] off;
        logic [LG:0]         s;
        row_part = '0;
        for (int l = 0; l < WORD_BYTES; l++) begin
            off = {1'b0, row_q, LG'(l)} - {1'b0, ad_q};
            s   = len_q - (LG+1)'(1) - off[LG:0];
            if (off < (ADDR_WIDTH+1)'(len_q))
                row_part[s*BYTE_W +: BYTE_W] = rdata[l*BYTE_W +: BYTE_W];
        end
    end

    always_comb begin
        logic [FULLW-1:0] raw;
        logic             sgn;
        raw      = part | row_part;
        sgn      = sext_q && (size_q != 2'b10) && raw[int'(len_q)*BYTE_W - 1];
        resp_val = raw;
        for (int b = 0; b < FULLW; b++)
            if (b >= int'(len_q) * BYTE_W)
                resp_val[b] = sgn;
        if (err_q)
            resp_val = '0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = (!err_in && cross_in) ? SPLIT : RESP;
            SPLIT:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ad_q   <= '0;
            d_q    <= '0;
            size_q <= '0;
            we_q   <= 1'b0;
            sext_q <= 1'b0;
            err_q  <= 1'b0;
            row_q  <= '0;
            part   <= '0;
            q_hold <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                ad_q   <= ad[ADDR_WIDTH-1:0];
                d_q    <= d;
                size_q <= size;
                we_q   <= we;
                sext_q <= sext;
                err_q  <= err_in;
                row_q  <= ad[ADDR_WIDTH-1:LG];
                part   <= '0;
            end
            if (state == SPLIT) begin
                part  <= row_part;
                row_q <= row_q + RW'(1);
            end
            if (state == RESP)
                q_hold <= resp_val;
        end
    end

    assign busy  = (state != IDLE);
    assign ready = (state == RESP);
    assign err   = ready && err_q;
    assign q     = ready ? resp_val : q_hold;

endmodule
